// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: ctrl bit positions, named ctrl
// words and the FSM state encoding.
package alu_pkg;

    localparam int unsigned CTRL_W = 6;

    localparam int unsigned ZX = 5;
    localparam int unsigned NX = 4;
    localparam int unsigned ZY = 3;
    localparam int unsigned NY = 2;
    localparam int unsigned F  = 1;
    localparam int unsigned NO = 0;

    localparam logic [CTRL_W-1:0] CTRL_ZERO      = 6'b101010;
    localparam logic [CTRL_W-1:0] CTRL_ONE       = 6'b111111;
    localparam logic [CTRL_W-1:0] CTRL_X_PLUS_1  = 6'b011111;
    localparam logic [CTRL_W-1:0] CTRL_X_MINUS_1 = 6'b001110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // y forced to all ones and ANDed with x, so x passes through to the no-stage
    function automatic logic [CTRL_W-1:0] pass_x_ctrl(input logic no);
        return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, no};
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: operand preprocess, add/and select and output invert.
// Also exposes the preprocessed operands so the multiplier can capture them.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  xa_c,
    output logic [WIDTH-1:0]  ya_c,
    output logic [WIDTH-1:0]  res_c
);

    always_comb begin
        xa_c = ctrl[ZX] ? '0 : x;
        if (ctrl[NX]) begin
            xa_c = ~xa_c;
        end
        ya_c = ctrl[ZY] ? '0 : y;
        if (ctrl[NY]) begin
            ya_c = ~ya_c;
        end
        res_c = ctrl[F] ? (xa_c + ya_c) : (xa_c & ya_c);
        if (ctrl[NO]) begin
            res_c = ~res_c;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ALU commands and an
// optional WIDTH-iteration shift-add multiplier sharing one combinational core.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              mul,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              zr,
    output logic              ng,
    output logic              busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             no_q, no_d;

    logic             out_valid_d, zr_d, ng_d, busy_d;
    logic [WIDTH-1:0] out_d;

    logic              accept_c;
    logic              is_mul_c;
    logic [WIDTH-1:0]  acc_sum_c;
    logic [WIDTH-1:0]  comb_x_c, comb_y_c;
    logic [CTRL_W-1:0] comb_ctrl_c;
    logic [WIDTH-1:0]  xa_c, ya_c, res_c;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept_c  = in_valid && in_ready;
    assign is_mul_c  = (MUL_EN != 0) && mul;
    assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    // During MUL the core only applies the captured no-bit to the final product
    always_comb begin
        comb_x_c    = x;
        comb_y_c    = y;
        comb_ctrl_c = ctrl;
        if (state_q == ST_MUL) begin
            comb_x_c    = acc_sum_c;
            comb_y_c    = '0;
            comb_ctrl_c = pass_x_ctrl(no_q);
        end
    end

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .x     (comb_x_c),
        .y     (comb_y_c),
        .ctrl  (comb_ctrl_c),
        .xa_c  (xa_c),
        .ya_c  (ya_c),
        .res_c (res_c)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        out_d       = out;
        zr_d        = zr;
        ng_d        = ng;
        busy_d      = busy;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        no_d        = no_q;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        state_d  = ST_MUL;
                        busy_d   = 1'b1;
                        mcand_d  = xa_c;
                        mplier_d = ya_c;
                        acc_d    = '0;
                        cnt_d    = '0;
                        no_d     = ctrl[NO];
                    end else begin
                        out_d       = res_c;
                        zr_d        = (res_c == '0);
                        ng_d        = res_c[WIDTH-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    out_d       = res_c;
                    zr_d        = (res_c == '0);
                    ng_d        = res_c[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            busy      <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            no_q      <= 1'b0;
        end else begin
            out_valid <= out_valid_d;
            out       <= out_d;
            zr        <= zr_d;
            ng        <= ng_d;
            busy      <= busy_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            no_q      <= no_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random streams checked against
// an arithmetic reference model; a second 8-bit instance has multiply removed.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned W8 = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, mul, out_valid, out_ready, zr, ng, busy;
    logic [W-1:0]  x, y, out;
    logic [5:0]    ctrl;

    logic          b_in_valid, b_in_ready, b_mul, b_out_valid, b_out_ready, b_zr, b_ng, b_busy;
    logic [W8-1:0] b_x, b_y, b_out;
    logic [5:0]    b_ctrl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .mul(mul), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .busy(busy)
    );

    alu_seq #(.WIDTH(W8), .MUL_EN(0)) dut8 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .ctrl(b_ctrl), .mul(b_mul), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out(b_out), .zr(b_zr), .ng(b_ng), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: straight arithmetic on masked integers, product via '*'
    function automatic logic [63:0] model(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic [5:0] c,
                                          input logic m);
        logic [63:0] mask, xa, ya, r;
        mask = (64'd1 << w) - 64'd1;
        xa = c[5] ? 64'd0 : (a & mask);
        if (c[4]) xa = ~xa & mask;
        ya = c[3] ? 64'd0 : (b & mask);
        if (c[2]) ya = ~ya & mask;
        if (m)         r = (xa * ya) & mask;
        else if (c[1]) r = (xa + ya) & mask;
        else           r = xa & ya;
        if (c[0]) r = ~r & mask;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_cmd(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                           input string tag);
        logic [15:0] e;
        e = 16'(model(W, 64'(a), 64'(b), c, 1'b0));
        in_valid = 1'b1; mul = 1'b0; x = a; y = b; ctrl = c; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check({tag, " out"}, 64'(out), 64'(e));
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " zr"}, 64'(zr), 64'(e == 16'd0));
        check({tag, " ng"}, 64'(ng), 64'(e[15]));
    endtask

    task automatic mul_cmd(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                           input string tag);
        logic [15:0] e;
        int edges, busy_cyc, rdy_seen;
        e = 16'(model(W, 64'(a), 64'(b), c, 1'b1));
        in_valid = 1'b1; mul = 1'b1; x = a; y = b; ctrl = c; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; mul = 1'b0;
        edges = 0; busy_cyc = 0; rdy_seen = 0;
        while (!out_valid && edges < 40) begin
            if (busy) busy_cyc++;
            if (in_ready) rdy_seen++;
            x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
            step();
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'(W));
        check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(W));
        check({tag, " in_ready_in_mul"}, 64'(rdy_seen), 64'd0);
        check({tag, " out"}, 64'(out), 64'(e));
        check({tag, " zr"}, 64'(zr), 64'(e == 16'd0));
        check({tag, " ng"}, 64'(ng), 64'(e[15]));
        check({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, b;
        logic [5:0]  c;
        int          seen, stalls;

        in_valid = 1'b0; mul = 1'b0; x = '0; y = '0; ctrl = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_mul = 1'b0; b_x = '0; b_y = '0; b_ctrl = '0; b_out_ready = 1'b1;

        step();
        step();
        check("rst out", 64'(out), 64'd0);
        check("rst zr", 64'(zr), 64'd1);
        check("rst ng", 64'(ng), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst8 out", 64'(b_out), 64'd0);
        check("rst8 zr", 64'(b_zr), 64'd1);
        reset = 1'b0;

        alu_cmd(16'h1234, 16'h5678, CTRL_ZERO, "zero");
        alu_cmd(16'h1234, 16'h5678, CTRL_ONE, "one");
        check("one literal", 64'(out), 64'h0001);
        alu_cmd(16'h0000, 16'h5678, CTRL_X_MINUS_1, "x_minus_1");
        check("x_minus_1 literal", 64'(out), 64'hFFFF);

        mul_cmd(16'd300, 16'd250, 6'b000010, "mul300");
        check("mul300 literal", 64'(out), 64'h24F8);
        mul_cmd(16'hFFFD, 16'd5, 6'b000010, "mul_neg");
        check("mul_neg literal", 64'(out), 64'hFFF1);

        // Backpressure: result 5 must hold while the consumer stalls
        alu_cmd(16'd2, 16'd3, 6'b000010, "five");
        out_ready = 1'b0;
        in_valid = 1'b1; mul = 1'b0; x = 16'd7; y = 16'd1; ctrl = 6'b000010;
        #1;
        check("stall in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            step();
            check("stall out", 64'(out), 64'h0005);
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall zr", 64'(zr), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("release out", 64'(out), 64'h0008);
        check("release out_valid", 64'(out_valid), 64'd1);
        step();
        check("retire out_valid", 64'(out_valid), 64'd0);
        check("retire out", 64'(out), 64'h0008);

        // Reset in the middle of a multiply; in_valid during reset is ignored
        in_valid = 1'b1; mul = 1'b1; x = 16'd300; y = 16'd250; ctrl = 6'b000010;
        step();
        in_valid = 1'b0; mul = 1'b0;
        repeat (7) step();
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        in_valid = 1'b1; x = 16'd5; ctrl = CTRL_ONE;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        check("abort out", 64'(out), 64'd0);
        check("abort zr", 64'(zr), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        check("abort no_result", 64'(seen), 64'd0);

        // Random ALU stream, one command per cycle
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 6'($urandom);
            in_valid = 1'b1; mul = 1'b0; x = a; y = b; ctrl = c;
            #1;
            if (!in_ready) stalls++;
            step();
            check("stream out", 64'(out), model(W, 64'(a), 64'(b), c, 1'b0));
            check("stream out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        check("stream stalls", 64'(stalls), 64'd0);

        for (int i = 0; i < 6; i++) begin
            mul_cmd(16'($urandom), 16'($urandom), 6'($urandom), "rand_mul");
        end

        // 8-bit instance without multiplier
        b_in_valid = 1'b1; b_mul = 1'b0; b_x = 8'h7F; b_y = 8'h00; b_ctrl = CTRL_X_PLUS_1;
        step();
        check("w8 x_plus_1 out", 64'(b_out), 64'h80);
        check("w8 x_plus_1 ng", 64'(b_ng), 64'd1);
        check("w8 x_plus_1 out_valid", 64'(b_out_valid), 64'd1);
        b_mul = 1'b1; b_x = 8'd3; b_y = 8'd5; b_ctrl = 6'b000010;
        #1;
        check("w8 mul in_ready", 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0; b_mul = 1'b0;
        check("w8 mul_as_alu out", 64'(b_out), model(W8, 64'd3, 64'd5, 6'b000010, 1'b0));
        check("w8 mul_as_alu out_valid", 64'(b_out_valid), 64'd1);
        check("w8 busy", 64'(b_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width, minimum 4.
REQ-002 SHALL have parameter MUL_EN, default 1: 1 enables multiply mode, 0 removes it.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operand/command presented.
REQ-007 in_ready  out  1  block can accept; transfer when in_valid && in_ready at an edge.
REQ-008 x  in  WIDTH  operand x.
REQ-009 y  in  WIDTH  operand y.
REQ-010 ctrl  in  6  {zx,nx,zy,ny,f,no}, bit 5 = zx.
REQ-011 mul  in  1  1 = multiply command; ignored when MUL_EN=0.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts; result retired when out_valid && out_ready at an edge.
REQ-014 out  out  WIDTH  registered result.
REQ-015 zr  out  1  registered, 1 iff out == 0.
REQ-016 ng  out  1  registered, equals out[WIDTH-1].
REQ-017 busy  out  1  1 while multiply in progress.

Function
REQ-018 Preprocess: xa = zx ? 0 : x, then xa = nx ? ~xa : xa; ya likewise with zy/ny.
REQ-019 ALU command (mul=0): r = f ? xa+ya (mod 2^WIDTH) : xa&ya, then r = no ? ~r : r.
REQ-020 Multiply command (mul=1, MUL_EN=1): r = low WIDTH bits of xa*ya, then r = no ? ~r : r; f ignored.
REQ-021 Multiply via shift-add: each MUL cycle, if multiplier LSB is 1, add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; exactly WIDTH iterations.
REQ-022 FSM states: IDLE, MUL.
REQ-023 IDLE -> MUL on accepted multiply command; MUL -> IDLE after WIDTH-th iteration, same edge loads out/zr/ng and sets out_valid.
REQ-024 in_ready = (state==IDLE) && (!out_valid || out_ready); in_ready is 0 throughout MUL.
REQ-025 ALU command latency 1: on the accepting edge out/zr/ng load and out_valid sets.
REQ-026 Multiply latency WIDTH+1: out_valid sets WIDTH edges after the accepting edge; busy=1 exactly during MUL.
REQ-027 Back-to-back ALU commands with out_ready=1 SHALL sustain one result per cycle.
REQ-028 out, zr, ng SHALL hold stable while out_valid && !out_ready.
REQ-029 Retire without new load: out_valid clears; out/zr/ng keep last values.
REQ-030 Simultaneous retire and ALU accept: out_valid stays 1, new result loads.
REQ-031 Multiply operands and ctrl SHALL be captured at accept; x/y/ctrl changes during MUL have no effect.
REQ-032 Overflow wraps silently for sum and product; no carry/overflow output.
REQ-033 MUL_EN=0: mul is ignored, command treated as ALU command; MUL state unreachable, busy tied 0.

Reset
REQ-034 reset=1 at an edge: state=IDLE, out_valid=0, out=0, zr=1, ng=0, busy=0, multiply registers cleared.
REQ-035 reset during MUL SHALL abort the multiply with no result produced; in_ready=1 on the first cycle after reset deasserts.
REQ-036 in_valid is ignored while reset=1.

Structure
REQ-037 Shared package alu_pkg SHALL hold ctrl bit indices (ZX..NO), FSM state encoding, and named ctrl constants (ZERO=101010, ONE=111111, X_PLUS_1=011111, X_MINUS_1=001110).
REQ-038 Combinational preprocess/f/no logic SHALL be one sub-module alu_comb (parameter WIDTH), instantiated once, reused for the no-stage of the product.
REQ-039 FSM, multiply datapath and output register SHALL live in alu_seq.

Verification
REQ-040 WIDTH=16, ctrl=101010, x=0x1234, y=0x5678 -> next cycle out=0x0000, zr=1, ng=0; ctrl=111111 -> out=0x0001, zr=0.
REQ-041 WIDTH=16, ctrl=001110, x=0 -> out=0xFFFF, ng=1; WIDTH=8, ctrl=011111, x=0x7F -> out=0x80, ng=1.
REQ-042 WIDTH=16, mul=1, ctrl=000010, x=300, y=250 -> busy=1 for 16 cycles, out_valid 16 edges after accept, out=0x24F8; x=0xFFFD, y=5 -> out=0xFFF1, ng=1.
REQ-043 Hold out_ready=0 after ALU result 0x0005 -> in_ready=0, out stays 0x0005; then out_ready=1 with new command -> next result loads same edge, out_valid stays 1.
REQ-044 Assert reset at cycle 8 of a multiply -> out_valid never set for it, out=0, zr=1, in_ready=1 after reset.
REQ-045 Stream 100 random ALU commands with out_ready=1 -> one result per cycle, all matching golden model.
